// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Drives an external bank of WIDTH JK flip-flops (with active-low bulk
// preset/clear) to a requested state and verifies the result through the
// bank's Q feedback. A request is latched in IDLE, excitation is presented
// for one DRIVE cycle, and the feedback is compared in the following CHECK
// cycle. A mismatch re-drives up to RETRIES extra times before an error
// completion is reported.
//
// Ports:
//   input_clock1_c_1   clock, rising edge (shared with the flip-flop bank)
//   input_reset1_rst_2 asynchronous active-high reset
//   req_valid          request present
//   req_ready          high while IDLE (combinational from state)
//   req_cmd            00 LOAD, 01 TOGGLE, 10 CLEAR, 11 PRESET
//   req_target         target state for LOAD, ignored otherwise
//   q_fb               Q outputs of the flip-flop bank (same clock domain)
//   jk_j / jk_k        registered J/K excitation
//   jk_preset_n        registered active-low preset to the whole bank
//   jk_clear_n         registered active-low clear to the whole bank
//   done_valid         one-cycle completion pulse
//   done_ok            1 when q_fb matched the target, valid with done_valid
//   done_q             q_fb sampled at the final CHECK, valid with done_valid
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int WIDTH   = 4,
    parameter int RETRIES = 2
) (
    input  logic             input_clock1_c_1,
    input  logic             input_reset1_rst_2,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_preset_n,
    output logic             jk_clear_n,
    output logic             done_valid,
    output logic             done_ok,
    output logic [WIDTH-1:0] done_q
);

    // Retry counter must hold 0..RETRIES; keep at least one bit when RETRIES=0.
    localparam int RCW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [RCW-1:0] RETRY_MAX = RCW'(RETRIES);

    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_TOGGLE = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_PRESET = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    // J excitation: set the bits that are 0 now and must become 1.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
        return ~q & t;
    endfunction

    // K excitation: reset the bits that are 1 now and must become 0.
    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
        return q & ~t;
    endfunction

    state_t           state_r;
    logic [1:0]       cmd_r;
    logic [WIDTH-1:0] target_r;
    logic [RCW-1:0]   retry_r;
    logic [WIDTH-1:0] jk_j_r;
    logic [WIDTH-1:0] jk_k_r;
    logic             jk_preset_n_r;
    logic             jk_clear_n_r;
    logic             done_valid_r;
    logic             done_ok_r;
    logic [WIDTH-1:0] done_q_r;

    logic [WIDTH-1:0] acc_target_s;
    logic [1:0]       sel_cmd_s;
    logic [WIDTH-1:0] sel_target_s;
    logic [WIDTH-1:0] drv_j_s;
    logic [WIDTH-1:0] drv_k_s;
    logic             drv_preset_n_s;
    logic             drv_clear_n_s;
    logic             match_s;

    // Target resolved from the incoming command; TOGGLE snapshots ~q_fb at accept.
    always_comb begin
        acc_target_s = {WIDTH{1'b0}};
        case (req_cmd)
            CMD_LOAD:   acc_target_s = req_target;
            CMD_TOGGLE: acc_target_s = ~q_fb;
            CMD_CLEAR:  acc_target_s = {WIDTH{1'b0}};
            CMD_PRESET: acc_target_s = {WIDTH{1'b1}};
            default:    acc_target_s = {WIDTH{1'b0}};
        endcase
    end

    // Command/target feeding the drive computation: fresh request in IDLE, latched ones on retry.
    always_comb begin
        sel_cmd_s    = cmd_r;
        sel_target_s = target_r;
        if (state_r == ST_IDLE) begin
            sel_cmd_s    = req_cmd;
            sel_target_s = acc_target_s;
        end else begin
            sel_cmd_s    = cmd_r;
            sel_target_s = target_r;
        end
    end

    // Drive values registered on the edge that enters DRIVE, using the live q_fb.
    always_comb begin
        drv_j_s        = {WIDTH{1'b0}};
        drv_k_s        = {WIDTH{1'b0}};
        drv_preset_n_s = 1'b1;
        drv_clear_n_s  = 1'b1;
        case (sel_cmd_s)
            CMD_LOAD, CMD_TOGGLE: begin
                drv_j_s = excite_j(q_fb, sel_target_s);
                drv_k_s = excite_k(q_fb, sel_target_s);
            end
            CMD_CLEAR:  drv_clear_n_s  = 1'b0;
            CMD_PRESET: drv_preset_n_s = 1'b0;
            default: begin
                drv_j_s = {WIDTH{1'b0}};
                drv_k_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Feedback compare used in CHECK.
    always_comb begin
        match_s = (q_fb == target_r);
    end

    // Sequencer: state, latched request, retry count and all registered outputs.
    always_ff @(posedge input_clock1_c_1 or posedge input_reset1_rst_2) begin
        if (input_reset1_rst_2) begin
            state_r       <= ST_IDLE;
            cmd_r         <= CMD_LOAD;
            target_r      <= {WIDTH{1'b0}};
            retry_r       <= {RCW{1'b0}};
            jk_j_r        <= {WIDTH{1'b0}};
            jk_k_r        <= {WIDTH{1'b0}};
            jk_preset_n_r <= 1'b1;
            jk_clear_n_r  <= 1'b1;
            done_valid_r  <= 1'b0;
            done_ok_r     <= 1'b0;
            done_q_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_valid_r <= 1'b0;
                    if (req_valid) begin
                        cmd_r         <= req_cmd;
                        target_r      <= acc_target_s;
                        retry_r       <= {RCW{1'b0}};
                        jk_j_r        <= drv_j_s;
                        jk_k_r        <= drv_k_s;
                        jk_preset_n_r <= drv_preset_n_s;
                        jk_clear_n_r  <= drv_clear_n_s;
                        state_r       <= ST_DRIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    // Bank has taken the excitation on this edge; go quiet for CHECK.
                    jk_j_r        <= {WIDTH{1'b0}};
                    jk_k_r        <= {WIDTH{1'b0}};
                    jk_preset_n_r <= 1'b1;
                    jk_clear_n_r  <= 1'b1;
                    done_valid_r  <= 1'b0;
                    state_r       <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (match_s) begin
                        done_valid_r <= 1'b1;
                        done_ok_r    <= 1'b1;
                        done_q_r     <= q_fb;
                        state_r      <= ST_IDLE;
                    end else if (retry_r < RETRY_MAX) begin
                        retry_r       <= retry_r + RCW'(1);
                        jk_j_r        <= drv_j_s;
                        jk_k_r        <= drv_k_s;
                        jk_preset_n_r <= drv_preset_n_s;
                        jk_clear_n_r  <= drv_clear_n_s;
                        done_valid_r  <= 1'b0;
                        state_r       <= ST_DRIVE;
                    end else begin
                        done_valid_r <= 1'b1;
                        done_ok_r    <= 1'b0;
                        done_q_r     <= q_fb;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe, quiet IDLE.
                    jk_j_r        <= {WIDTH{1'b0}};
                    jk_k_r        <= {WIDTH{1'b0}};
                    jk_preset_n_r <= 1'b1;
                    jk_clear_n_r  <= 1'b1;
                    done_valid_r  <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign jk_j        = jk_j_r;
    assign jk_k        = jk_k_r;
    assign jk_preset_n = jk_preset_n_r;
    assign jk_clear_n  = jk_clear_n_r;
    assign done_valid  = done_valid_r;
    assign done_ok     = done_ok_r;
    assign done_q      = done_q_r;

    jk_excitation_driver_checker #(.WIDTH(WIDTH)) u_checker (
        .clk         (input_clock1_c_1),
        .rst         (input_reset1_rst_2),
        .jk_j        (jk_j_r),
        .jk_k        (jk_k_r),
        .jk_preset_n (jk_preset_n_r),
        .jk_clear_n  (jk_clear_n_r),
        .done_valid  (done_valid_r)
    );

endmodule

// ---------------------------------------------------------------------------
// jk_excitation_driver_checker
//
// Protocol properties of the driver outputs: preset and clear never low
// together, each bulk pulse lasts one cycle, J and K never both set on the
// same bit, and completion is a single-cycle pulse.
//
// Ports: clk, rst, and the registered driver outputs being observed.
// ---------------------------------------------------------------------------
module jk_excitation_driver_checker #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] jk_j,
    input logic [WIDTH-1:0] jk_k,
    input logic             jk_preset_n,
    input logic             jk_clear_n,
    input logic             done_valid
);

    a_no_both_low: assert property (@(posedge clk) disable iff (rst)
        !(!jk_preset_n && !jk_clear_n));

    a_preset_one_cycle: assert property (@(posedge clk) disable iff (rst)
        !jk_preset_n |=> jk_preset_n);

    a_clear_one_cycle: assert property (@(posedge clk) disable iff (rst)
        !jk_clear_n |=> jk_clear_n);

    a_jk_exclusive: assert property (@(posedge clk) disable iff (rst)
        (jk_j & jk_k) == {WIDTH{1'b0}});

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done_valid |=> !done_valid);

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_cmd;
    logic [W-1:0] req_target;
    logic [W-1:0] q_fb;
    logic [W-1:0] jk_j;
    logic [W-1:0] jk_k;
    logic         jk_preset_n;
    logic         jk_clear_n;
    logic         done_valid;
    logic         done_ok;
    logic [W-1:0] done_q;

    // Flip-flop bank model plus a load port and a stuck-feedback override.
    logic [W-1:0] bank_q;
    logic [W-1:0] bank_val;
    logic         bank_load;
    logic         stuck_en;
    logic [W-1:0] stuck_val;

    int n_cmp  = 0;
    int n_fail = 0;
    int drives;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(W), .RETRIES(2)) dut (
        .input_clock1_c_1   (clk),
        .input_reset1_rst_2 (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_cmd            (req_cmd),
        .req_target         (req_target),
        .q_fb               (q_fb),
        .jk_j               (jk_j),
        .jk_k               (jk_k),
        .jk_preset_n        (jk_preset_n),
        .jk_clear_n         (jk_clear_n),
        .done_valid         (done_valid),
        .done_ok            (done_ok),
        .done_q             (done_q)
    );

    always @(posedge clk) begin
        if (bank_load)        bank_q <= bank_val;
        else if (!jk_clear_n) bank_q <= 4'b0000;
        else if (!jk_preset_n) bank_q <= 4'b1111;
        else                  bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
    end

    assign q_fb = stuck_en ? stuck_val : bank_q;

    typedef struct {
        logic [1:0]   cmd;
        logic [W-1:0] tgt;
        logic [W-1:0] init;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic         epn;
        logic         ecn;
        logic [W-1:0] eq;
    } vec_t;

    vec_t vecs [6];

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input logic [W-1:0] v);
        bank_load = 1'b1;
        bank_val  = v;
        tick();
        bank_load = 1'b0;
    endtask

    initial begin
        //            cmd    tgt      init     J        K        pn    cn    done_q
        vecs[0] = '{2'b00, 4'b1010, 4'b0110, 4'b1000, 4'b0100, 1'b1, 1'b1, 4'b1010};
        vecs[1] = '{2'b01, 4'b0000, 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b1, 4'b1100};
        vecs[2] = '{2'b10, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000};
        vecs[3] = '{2'b11, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111};
        vecs[4] = '{2'b00, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0101};
        vecs[5] = '{2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 2'b00;
        req_target = 4'b0000;
        bank_load  = 1'b1;
        bank_val   = 4'b0000;
        stuck_en   = 1'b0;
        stuck_val  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check4("rst_j", jk_j, 4'b0000);
        check4("rst_k", jk_k, 4'b0000);
        check1("rst_preset_n", jk_preset_n, 1'b1);
        check1("rst_clear_n", jk_clear_n, 1'b1);
        check1("rst_done_valid", done_valid, 1'b0);
        check1("rst_done_ok", done_ok, 1'b0);
        check4("rst_done_q", done_q, 4'b0000);
        check1("rst_ready", req_ready, 1'b1);
        rst       = 1'b0;
        bank_load = 1'b0;
        tick();

        // Table-driven single commands
        for (int i = 0; i < 6; i++) begin
            set_bank(vecs[i].init);
            req_valid  = 1'b1;
            req_cmd    = vecs[i].cmd;
            req_target = vecs[i].tgt;
            check1($sformatf("v%0d_ready_idle", i), req_ready, 1'b1);
            tick();
            req_valid = 1'b0;
            check4($sformatf("v%0d_drive_j", i), jk_j, vecs[i].ej);
            check4($sformatf("v%0d_drive_k", i), jk_k, vecs[i].ek);
            check1($sformatf("v%0d_drive_pn", i), jk_preset_n, vecs[i].epn);
            check1($sformatf("v%0d_drive_cn", i), jk_clear_n, vecs[i].ecn);
            check1($sformatf("v%0d_drive_ready", i), req_ready, 1'b0);
            tick();
            check4($sformatf("v%0d_check_j", i), jk_j, 4'b0000);
            check4($sformatf("v%0d_check_k", i), jk_k, 4'b0000);
            check1($sformatf("v%0d_check_pn", i), jk_preset_n, 1'b1);
            check1($sformatf("v%0d_check_cn", i), jk_clear_n, 1'b1);
            check1($sformatf("v%0d_check_dv", i), done_valid, 1'b0);
            tick();
            check1($sformatf("v%0d_done_valid", i), done_valid, 1'b1);
            check1($sformatf("v%0d_done_ok", i), done_ok, 1'b1);
            check4($sformatf("v%0d_done_q", i), done_q, vecs[i].eq);
            check1($sformatf("v%0d_done_ready", i), req_ready, 1'b1);
        end

        // CLEAR then PRESET issued in CLEAR's done cycle
        set_bank(4'b1010);
        req_valid = 1'b1;
        req_cmd   = 2'b10;
        tick();
        req_valid = 1'b0;
        check1("b2b_clear_cn", jk_clear_n, 1'b0);
        check1("b2b_clear_pn", jk_preset_n, 1'b1);
        tick();
        check1("b2b_clear_cn_rel", jk_clear_n, 1'b1);
        tick();
        check1("b2b_clear_done", done_valid, 1'b1);
        check4("b2b_clear_q", done_q, 4'b0000);
        check1("b2b_clear_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_cmd   = 2'b11;
        tick();
        req_valid = 1'b0;
        check1("b2b_preset_pn", jk_preset_n, 1'b0);
        check1("b2b_preset_cn", jk_clear_n, 1'b1);
        check1("b2b_preset_dv_low", done_valid, 1'b0);
        tick();
        check1("b2b_preset_pn_rel", jk_preset_n, 1'b1);
        tick();
        check1("b2b_preset_done", done_valid, 1'b1);
        check1("b2b_preset_ok", done_ok, 1'b1);
        check4("b2b_preset_q", done_q, 4'b1111);

        // Stuck bank: three DRIVE attempts, error completion 6 cycles after accept
        stuck_en   = 1'b1;
        stuck_val  = 4'b0000;
        req_valid  = 1'b1;
        req_cmd    = 2'b00;
        req_target = 4'b0001;
        tick();
        req_valid = 1'b0;
        drives    = 0;
        for (int c = 0; c < 6; c++) begin
            if (jk_j == 4'b0001) drives++;
            check1($sformatf("stuck_dv_c%0d", c), done_valid, 1'b0);
            tick();
        end
        n_cmp++;
        if (drives != 3) begin
            n_fail++;
            $display("FAIL stuck_drive_count: got %0d, expected 3", drives);
        end
        check1("stuck_done_valid", done_valid, 1'b1);
        check1("stuck_done_ok", done_ok, 1'b0);
        check4("stuck_done_q", done_q, 4'b0000);
        stuck_en = 1'b0;

        // Reset during DRIVE of a CLEAR
        set_bank(4'b1111);
        req_valid = 1'b1;
        req_cmd   = 2'b10;
        tick();
        req_valid = 1'b0;
        check1("rstmid_cn_low", jk_clear_n, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check1("rstmid_cn_async", jk_clear_n, 1'b1);
        check1("rstmid_pn", jk_preset_n, 1'b1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check1($sformatf("rstmid_dv_c%0d", c), done_valid, 1'b0);
            check1($sformatf("rstmid_ready_c%0d", c), req_ready, 1'b1);
            tick();
        end

        // Request held through CHECK with a changed target
        set_bank(4'b0000);
        req_valid  = 1'b1;
        req_cmd    = 2'b00;
        req_target = 4'b0011;
        tick();
        req_target = 4'b1100;
        check4("hold_drive_j", jk_j, 4'b0011);
        check4("hold_drive_k", jk_k, 4'b0000);
        tick();
        check1("hold_check_ready", req_ready, 1'b0);
        tick();
        check1("hold_done1_valid", done_valid, 1'b1);
        check1("hold_done1_ok", done_ok, 1'b1);
        check4("hold_done1_q", done_q, 4'b0011);
        tick();
        req_valid = 1'b0;
        check4("hold_drive2_j", jk_j, 4'b1100);
        check4("hold_drive2_k", jk_k, 4'b0011);
        tick();
        tick();
        check1("hold_done2_valid", done_valid, 1'b1);
        check1("hold_done2_ok", done_ok, 1'b1);
        check4("hold_done2_q", done_q, 4'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Sequencer that drives an external bank of WIDTH JK flip-flops (with active-low preset/clear) to a requested state, then checks the result through Q feedback. It computes J/K excitation from the current Q and the target, pulses preset/clear for bulk commands, retries on mismatch, and reports completion with status. It is the driving side of the flip-flop interface. A JK flip-flop bank sits downstream on the same clock. A request source or test controller sits upstream.

## Interface
- WIDTH, 4: number of JK flip-flops driven
- RETRIES, 2: extra DRIVE attempts after a failed CHECK before reporting error

Ports:
- input_clock1_c_1  in  1  single clock, rising edge; the flip-flop bank uses the same clock
- input_reset1_rst_2  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE (combinational from state)
- req_cmd  in  2  00 LOAD, 01 TOGGLE, 10 CLEAR, 11 PRESET
- req_target  in  WIDTH  target state for LOAD; ignored otherwise
- q_fb  in  WIDTH  Q outputs of the flip-flop bank
- jk_j  out  WIDTH  J drive, registered
- jk_k  out  WIDTH  K drive, registered
- jk_preset_n  out  1  active-low preset to all flip-flops, registered
- jk_clear_n  out  1  active-low clear to all flip-flops, registered
- done_valid  out  1  one-cycle completion pulse
- done_ok  out  1  1 means q_fb matched target; valid with done_valid
- done_q  out  WIDTH  q_fb sampled at final CHECK; valid with done_valid

## Operation
- States: IDLE, DRIVE, CHECK.
- Request is accepted when req_valid and req_ready are both high on a clock edge. Accept latches cmd and target:
  - LOAD: target = req_target.
  - TOGGLE: target = ~q_fb, sampled at accept.
  - CLEAR: target = 0.
  - PRESET: target = all ones.
- IDLE -> DRIVE on accept. The retry count is cleared.
- DRIVE lasts one cycle. It registers the drive outputs so they are visible during this cycle:
  - LOAD/TOGGLE: per bit, J = ~q & t and K = q & ~t. Equal bits get J=K=0 (hold).
  - CLEAR: jk_clear_n=0, J=K=0.
  - PRESET: jk_preset_n=0, J=K=0.
  - The bank updates on the edge that ends DRIVE.
- DRIVE -> CHECK unconditionally. On entering CHECK, J=K=0, preset_n=1 and clear_n=1.
- CHECK lasts one cycle and compares q_fb with target:
  - Match: done_valid=1, done_ok=1, go to IDLE.
  - Mismatch with retry count < RETRIES: increment the count, go to DRIVE. J/K are recomputed from the current q_fb.
  - Mismatch with retry count = RETRIES: done_valid=1, done_ok=0, go to IDLE.
- done_valid, done_ok and done_q are registered at the end of CHECK. They are visible for exactly one cycle, the first IDLE cycle.
- req_ready is high in that same cycle, so back-to-back requests are allowed. There is no backpressure on done.
- req_valid while not in IDLE is ignored. The request must be held upstream.
- Reset values, and state during reset: IDLE; jk_j=0, jk_k=0, jk_preset_n=1, jk_clear_n=1, done_valid=0, done_ok=0, done_q=0, retry count 0.
- Reset mid-operation aborts the command with no done pulse. Preset/clear are released immediately (asynchronously).

## Timing
- Accept at edge N.
- DRIVE outputs are valid in cycle N..N+1 and the bank updates at edge N+1.
- CHECK is cycle N+1..N+2; q_fb is sampled at edge N+2.
- done_valid is high in cycle N+2..N+3.
- Success latency: 2 cycles from accept edge to done. Each retry adds 2 cycles.
- Worst case: 2·(RETRIES+1) cycles.
- Preset/clear low pulse: exactly one cycle per DRIVE, never both low together.
- q_fb is treated as synchronous to input_clock1_c_1. There is no synchronizer.

## Test plan
- Reset, then LOAD target=4'b1010 with bank at 4'b0110 -> in DRIVE, J=4'b1000, K=4'b0100. done_valid 2 cycles after accept with done_ok=1, done_q=4'b1010.
- TOGGLE with bank at 4'b0011 -> J=4'b1100, K=4'b0011. done_q=4'b1100, done_ok=1.
- CLEAR, then PRESET back-to-back: issue PRESET in the done cycle of CLEAR -> jk_clear_n low for one cycle, then jk_preset_n low for one cycle. done_q=0, then 4'b1111. No idle gap.
- Stuck bank model (q_fb frozen at 4'b0000), LOAD 4'b0001 with RETRIES=2 -> 3 DRIVE cycles. done_ok=0 and done_q=0 at cycle 6 after accept.
- Assert reset during DRIVE of a CLEAR -> jk_clear_n returns to 1 asynchronously. No done_valid. req_ready=1 after release.
- req_valid held during CHECK with a different target -> not accepted until IDLE. The first command's done reflects only the first target.
